// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between fetch and data ports, one transaction at a time.
// Optional SRAM_ARB_RR_EN: round-robin tie-break instead of fixed MEM priority.
module sram_arbiter #(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_resp,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_owns,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [31:0] ram_data_o,
  output logic        ram_data_oe,
  input  logic [31:0] ram_data_i
);
  typedef enum logic [2:0] {IDLE, RD, WR, TURN, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, be_n_q, be_n_d;
  logic owner_q, owner_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic grant_mem, accept, wr_req;
  logic unused_bits;
  assign unused_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};
`ifdef SRAM_ARB_RR_EN
  logic last_q;
  // last_q: 1 when MEM was granted last, so a tie goes to IF
  assign grant_mem = mem_req && (!if_req || !last_q);
  always_ff @(posedge clk)
    if (reset) last_q <= 1'b0;
    else if (accept) last_q <= grant_mem;
`else
  assign grant_mem = mem_req;
`endif
  assign accept = (state_q == IDLE) && !reset && (mem_req || if_req);
  assign wr_req = grant_mem && (mem_we != 4'b0000);
  assign mem_ack = accept && grant_mem;
  assign if_ack = accept && !grant_mem;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      owner_q <= 1'b0;
      addr_q <= '0;
      be_n_q <= 4'b1111;
      wdata_q <= '0;
      if_rdata_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      owner_q <= owner_d;
      addr_q <= addr_d;
      be_n_q <= be_n_d;
      wdata_q <= wdata_d;
      if_rdata_q <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - {3'b000, cnt_q != 4'd0};
    owner_d = owner_q;
    addr_d = addr_q;
    be_n_d = be_n_q;
    wdata_d = wdata_q;
    if_rdata_d = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        owner_d = grant_mem;
        addr_d = grant_mem ? mem_addr[21:2] : if_addr[21:2];
        be_n_d = wr_req ? ~mem_we : 4'b0000;
        wdata_d = mem_wdata;
        state_d = wr_req ? WR : RD;
        cnt_d = wr_req ? 4'(WRITE_CYCLES - 1) : 4'(READ_CYCLES - 1);
      end
      RD: if (cnt_q == 4'd0) begin
        state_d = RESP;
        if (owner_q) mem_rdata_d = ram_data_i;
        else if_rdata_d = ram_data_i;
      end
      WR: state_d = (cnt_q == 4'd0) ? TURN : WR;
      TURN: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ram_ce_n = !(state_q == RD || state_q == WR || state_q == TURN);
    ram_oe_n = state_q != RD;
    ram_we_n = state_q != WR;
    ram_data_oe = state_q == WR || state_q == TURN;
    ram_data_o = wdata_q;
    ram_addr = addr_q;
    ram_be_n = be_n_q;
    if_resp = state_q == RESP && !owner_q;
    mem_resp = state_q == RESP && owner_q;
    mem_owns = state_q != IDLE && owner_q;
    if_rdata = if_rdata_q;
    mem_rdata = mem_rdata_q;
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks against a transaction-timeline model.
module tb_sram_arbiter;
  localparam int RC = 2, WC = 2;
  logic clk = 0, reset = 1;
  logic if_req, if_ack, if_resp, mem_req, mem_ack, mem_resp, mem_owns;
  logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata, ram_data_o, ram_data_i;
  logic [3:0] mem_we, ram_be_n;
  logic [19:0] ram_addr;
  logic ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe;
  logic b_if_req, b_if_ack, b_if_resp, b_mem_ack, b_mem_resp, b_mem_owns;
  logic [31:0] b_if_addr, b_if_rdata, b_mem_rdata, b_ram_data_o, b_ram_data_i;
  logic [3:0] b_ram_be_n;
  logic [19:0] b_ram_addr;
  logic b_ram_ce_n, b_ram_oe_n, b_ram_we_n, b_ram_data_oe;
  int cyc = 0, checks = 0, errors = 0;

  sram_arbiter #(.READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_resp(if_resp), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_owns(mem_owns),
    .ram_addr(ram_addr), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .ram_data_o(ram_data_o), .ram_data_oe(ram_data_oe), .ram_data_i(ram_data_i));

  sram_arbiter #(.READ_CYCLES(1), .WRITE_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_resp(b_if_resp), .if_rdata(b_if_rdata),
    .mem_req(1'b0), .mem_we(4'b0000), .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_ack(b_mem_ack), .mem_resp(b_mem_resp), .mem_rdata(b_mem_rdata), .mem_owns(b_mem_owns),
    .ram_addr(b_ram_addr), .ram_be_n(b_ram_be_n), .ram_ce_n(b_ram_ce_n), .ram_oe_n(b_ram_oe_n),
    .ram_we_n(b_ram_we_n), .ram_data_o(b_ram_data_o), .ram_data_oe(b_ram_data_oe), .ram_data_i(b_ram_data_i));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: a transaction is an offset t (1..end) from its accept cycle; outputs follow from t.
  bit armed = 0, busy = 0, kwr = 0, kown = 0, last = 0;
  int t = 0;
  logic [19:0] maddr = '0;
  logic [3:0] mbe = '0;
  logic [31:0] mwd = '0, m_if_rd = '0, m_mem_rd = '0;
  always @(negedge clk) begin
    bit e_mem, e_if, acc, trn, rsp;
    int len;
    if (reset || busy) begin
      e_mem = 0;
      e_if = 0;
    end else if (mem_req && if_req) begin
`ifdef SRAM_ARB_RR_EN
      e_mem = !last;
`else
      e_mem = 1;
`endif
      e_if = !e_mem;
    end else begin
      e_mem = mem_req;
      e_if = if_req;
    end
    len = kwr ? WC : RC;
    acc = busy && t <= len;
    trn = busy && kwr && t == WC + 1;
    rsp = busy && t == len + (kwr ? 2 : 1);
    if (armed) begin
      chk("if_ack", {31'b0, if_ack}, {31'b0, e_if});
      chk("mem_ack", {31'b0, mem_ack}, {31'b0, e_mem});
      chk("ce_n", {31'b0, ram_ce_n}, {31'b0, !(acc || trn)});
      chk("oe_n", {31'b0, ram_oe_n}, {31'b0, !(acc && !kwr)});
      chk("we_n", {31'b0, ram_we_n}, {31'b0, !(acc && kwr)});
      chk("data_oe", {31'b0, ram_data_oe}, {31'b0, kwr && (acc || trn)});
      chk("if_resp", {31'b0, if_resp}, {31'b0, rsp && !kown});
      chk("mem_resp", {31'b0, mem_resp}, {31'b0, rsp && kown});
      chk("mem_owns", {31'b0, mem_owns}, {31'b0, busy && kown});
      chk("if_rdata", if_rdata, m_if_rd);
      chk("mem_rdata", mem_rdata, m_mem_rd);
      if (busy) begin
        chk("ram_addr", {12'b0, ram_addr}, {12'b0, maddr});
        chk("ram_be_n", {28'b0, ram_be_n}, {28'b0, mbe});
        if (kwr) chk("ram_data_o", ram_data_o, mwd);
      end
    end
    if (reset) begin
      armed = 1;
      busy = 0;
      last = 0;
      m_if_rd = '0;
      m_mem_rd = '0;
    end else if (busy) begin
      if (!kwr && t == RC) begin
        if (kown) m_mem_rd = ram_data_i;
        else m_if_rd = ram_data_i;
      end
      if (rsp) busy = 0;
      else t++;
    end else if (e_mem || e_if) begin
      busy = 1;
      t = 1;
      kown = e_mem;
      last = e_mem;
      kwr = e_mem && mem_we != 4'b0000;
      maddr = e_mem ? mem_addr[21:2] : if_addr[21:2];
      mbe = kwr ? ~mem_we : 4'b0000;
      mwd = mem_wdata;
    end
  end

  initial begin
    int n, t0;
    logic [3:0] got, exp_order;
    bit ai, am;
    if_req = 1; mem_req = 1; if_addr = 32'h80000000; mem_addr = 32'h80000100;
    mem_we = 4'b0000; mem_wdata = '0; ram_data_i = 32'h5A5A0000;
    b_if_req = 0; b_if_addr = '0; b_ram_data_i = '0;
    tick;
    repeat (2) begin
      @(negedge clk);
      chk("rst_if_ack", {31'b0, if_ack}, 0);
      chk("rst_mem_ack", {31'b0, mem_ack}, 0);
      chk("rst_strobes", {29'b0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
      chk("rst_be_n", {28'b0, ram_be_n}, 32'hf);
      chk("rst_data_oe", {31'b0, ram_data_oe}, 0);
      chk("rst_rdata", if_rdata | mem_rdata, 0);
      tick;
    end
    reset = 0;
    n = 0;
    got = '0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (mem_ack || if_ack) begin
        got[n] = mem_ack;
        n++;
      end
    end
`ifdef SRAM_ARB_RR_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    chk("tie_ack_count", n, 4);
    chk("tie_ack_order", {28'b0, got}, {28'b0, exp_order});
    tick;
    if_req = 0; mem_req = 0;
    repeat (8) tick;
    if_req = 1; if_addr = 32'h80000010; ram_data_i = 32'h12345678;
    @(negedge clk);
    chk("rd_if_ack", {31'b0, if_ack}, 1);
    tick;
    if_req = 0;
    @(negedge clk);
    chk("rd_ram_addr", {12'b0, ram_addr}, 32'h4);
    chk("rd_oe_n1", {31'b0, ram_oe_n}, 0);
    tick;
    @(negedge clk);
    chk("rd_oe_n2", {31'b0, ram_oe_n}, 0);
    tick;
    @(negedge clk);
    chk("rd_if_resp", {31'b0, if_resp}, 1);
    chk("rd_if_rdata", if_rdata, 32'h12345678);
    chk("rd_oe_n3", {31'b0, ram_oe_n}, 1);
    tick;
    mem_req = 1; mem_we = 4'b0010; mem_addr = 32'h80400008; mem_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("wr_mem_ack", {31'b0, mem_ack}, 1);
    tick;
    mem_req = 0; mem_we = 4'b0000;
    @(negedge clk);
    chk("wr_ram_addr", {12'b0, ram_addr}, 32'h2);
    chk("wr_be_n", {28'b0, ram_be_n}, 32'hd);
    chk("wr_we_n1", {31'b0, ram_we_n}, 0);
    chk("wr_data_oe1", {31'b0, ram_data_oe}, 1);
    chk("wr_data_o", ram_data_o, 32'hAABBCCDD);
    tick;
    @(negedge clk);
    chk("wr_we_n2", {31'b0, ram_we_n}, 0);
    tick;
    @(negedge clk);
    chk("wr_turn", {30'b0, ram_we_n, ram_data_oe}, 32'h3);
    tick;
    @(negedge clk);
    chk("wr_mem_resp", {31'b0, mem_resp}, 1);
    chk("wr_data_oe4", {31'b0, ram_data_oe}, 0);
    tick;
    if_req = 1; if_addr = 32'h80000020;
    @(negedge clk);
    chk("ab_if_ack", {31'b0, if_ack}, 1);
    tick;
    if_req = 0; reset = 1;
    @(negedge clk);
    tick;
    reset = 0;
    @(negedge clk);
    chk("ab_strobes", {29'b0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
    repeat (4) begin
      tick;
      @(negedge clk);
      chk("ab_no_resp", {31'b0, if_resp}, 0);
    end
    tick;
    if_req = 1; if_addr = 32'h80000030; ram_data_i = 32'h0BADF00D;
    @(negedge clk);
    chk("ab2_if_ack", {31'b0, if_ack}, 1);
    tick;
    if_req = 0;
    tick;
    tick;
    @(negedge clk);
    chk("ab2_if_resp", {31'b0, if_resp}, 1);
    chk("ab2_if_rdata", if_rdata, 32'h0BADF00D);
    tick;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ai = if_ack;
      am = mem_ack;
      tick;
      if (!if_req || ai) begin
        if_req = ($urandom_range(0, 2) == 0);
        if_addr = $urandom;
      end
      if (!mem_req || am) begin
        mem_req = ($urandom_range(0, 2) == 0);
        mem_addr = $urandom;
        mem_wdata = $urandom;
        mem_we = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
      end
      ram_data_i = $urandom;
      reset = ($urandom_range(0, 199) == 0);
    end
    tick;
    if_req = 0; mem_req = 0; reset = 0;
    repeat (10) tick;
    b_if_req = 1; b_if_addr = 32'h80000000; b_ram_data_i = 32'hCAFE0001;
    @(negedge clk);
    chk("b_ack1", {31'b0, b_if_ack}, 1);
    t0 = cyc;
    tick;
    b_if_addr = 32'h80000004;
    @(negedge clk);
    chk("b_addr1", {12'b0, b_ram_addr}, 32'h0);
    chk("b_oe_n1", {31'b0, b_ram_oe_n}, 0);
    chk("b_no_ack", {31'b0, b_if_ack}, 0);
    tick;
    b_ram_data_i = 32'hCAFE0002;
    @(negedge clk);
    chk("b_resp1", {31'b0, b_if_resp}, 1);
    chk("b_rdata1", b_if_rdata, 32'hCAFE0001);
    tick;
    @(negedge clk);
    chk("b_ack2", {31'b0, b_if_ack}, 1);
    chk("b_ack_gap", cyc - t0, 3);
    tick;
    b_if_req = 0;
    @(negedge clk);
    chk("b_addr2", {12'b0, b_ram_addr}, 32'h1);
    tick;
    @(negedge clk);
    chk("b_resp2", {31'b0, b_if_resp}, 1);
    chk("b_rdata2", b_if_rdata, 32'hCAFE0002);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one external asynchronous SRAM (BaseRAM) between the instruction-fetch port and the data-memory port of the 5-stage pipeline. It accepts one transaction at a time, sequences the SRAM control strobes (ce_n/oe_n/we_n, byte enables, data-bus drive) over a parameterised number of cycles, and returns read data with a one-cycle response pulse. It sits between if_stage/mem_stage and the top-level tristate pads.

## Interface
- READ_CYCLES, 2, cycles oe_n is held low per read; legal 1..15
- WRITE_CYCLES, 2, cycles we_n is held low per write; legal 1..15

Clock is `clk`; reset is `reset`, synchronous, active-high.
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  fetch request accepted this cycle
- if_resp  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched word
- mem_req  in  1  data request; held with mem_addr, mem_we and mem_wdata stable until mem_ack
- mem_we  in  4  byte write enables; 4'b0000 = read
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data
- mem_ack  out  1  data request accepted this cycle
- mem_resp  out  1  one-cycle pulse: read data valid, or write complete
- mem_rdata  out  32  loaded word
- mem_owns  out  1  high while a MEM transaction is in flight (ACCESS/TURN/RESP)
- ram_addr  out  20  word address = latched addr[21:2]
- ram_be_n  out  4  byte enables, active low
- ram_ce_n / ram_oe_n / ram_we_n  out  1 each  chip select / output enable / write enable, active low
- ram_data_o  out  32  write data toward pad
- ram_data_oe  out  1  pad drive enable; the top level builds the tristate
- ram_data_i  in  32  data from pad

## Operation
- States: IDLE, RD, WR, TURN, RESP.
- IDLE: winner = MEM if mem_req, else IF if if_req. ack = winner and state==IDLE, combinational. On ack, latch addr, we, wdata and owner. Go to RD (we==0) or WR. Load counter with READ_CYCLES-1 or WRITE_CYCLES-1.
- RD: ce_n=0, oe_n=0, we_n=1, be_n=4'b0000, data_oe=0. Decrement counter. When counter==0, capture ram_data_i into the owner's rdata register and go to RESP.
- WR: ce_n=0, oe_n=1, we_n=0, be_n=~we, data_oe=1, ram_data_o=wdata. When counter==0, go to TURN.
- TURN: we_n=1, ce_n=0, data_oe=1, data held. This gives hold time. Next state is RESP.
- RESP: all strobes high, data_oe=0. Pulse the owner's resp for one cycle. Next state is IDLE.
- Requests arriving outside IDLE are not acked; they wait.
- rdata registers hold their value until the next read for the same port.
- The counter is 4 bits and never wraps below 0.
- mem_we of any non-zero pattern (e.g. 4'b0110) is a write.
- The arbiter ignores addr[31:22] and addr[1:0]. Decode is done upstream.

## Timing
- Reset values:
  - state = IDLE
  - ram_ce_n = ram_oe_n = ram_we_n = 1
  - ram_be_n = 4'b1111
  - ram_data_oe = 0
  - ram_addr = 0, ram_data_o = 0
  - if_resp = mem_resp = 0, mem_owns = 0
  - if_rdata = mem_rdata = 0
  - acks = 0 while reset is high
- Read accepted in cycle N:
  - RD occupies N+1 .. N+READ_CYCLES.
  - resp is asserted in cycle N+READ_CYCLES+1.
  - Next accept is possible at the earliest in N+READ_CYCLES+2.
- Write accepted in cycle N:
  - WR occupies N+1 .. N+WRITE_CYCLES.
  - TURN is N+WRITE_CYCLES+1.
  - resp is asserted in N+WRITE_CYCLES+2.
- ram_addr/ram_be_n change only on the accept edge, so they are stable for the whole access.
- If both requests are present in IDLE, exactly one ack is raised.
- Reset during any state: on the next edge, state = IDLE, all strobes are deasserted, data_oe = 0, and no resp is issued. The aborted transaction is lost.

## Configuration
- SRAM_ARB_RR_EN defined:
  - Ties go to the port not granted last. A 1-bit last_grant register resets to IF, so MEM wins the first tie.
  - Under continuous MEM requests, IF is served every other transaction.
- Undefined:
  - Fixed MEM priority. IF may starve while mem_req stays high; this is accepted because the pipeline stalls fetch on mem_owns.

## Test plan
- Reset sequence:
  - Hold reset 3 cycles with both requests high.
  - Expect: no ack; strobes 1; ram_be_n=4'b1111; data_oe=0; rdata 0.
- IF read (READ_CYCLES=2):
  - if_addr=0x80000010, ram_data_i=0x12345678.
  - Expect: if_ack in N; ram_addr=0x00004; oe_n low in N+1..N+2; if_resp and if_rdata=0x12345678 in N+3.
- MEM byte store (WRITE_CYCLES=2):
  - mem_we=4'b0010, mem_addr=0x80400008, mem_wdata=0xAABBCCDD.
  - Expect: ram_addr=0x00002; ram_be_n=4'b1101; we_n low in N+1..N+2; data_oe high in N+1..N+3; mem_resp in N+4.
- Simultaneous continuous requests from both ports:
  - Without the macro: expect four consecutive mem_acks and no if_ack.
  - With SRAM_ARB_RR_EN: expect acks in the order MEM, IF, MEM, IF.
- Reset asserted in the first RD cycle:
  - Expect: next cycle strobes high, IDLE, no if_resp ever; a fresh request afterwards completes normally.
- READ_CYCLES=1, back-to-back IF reads of 0x80000000 and 0x80000004:
  - Expect: acks 3 cycles apart; ram_addr values 0x00000 then 0x00001.
